flappy_mmio_responder: RTL and testbench

- Memory-mapped I/O responder on the pipelined processor's data-memory port, serving as the target end of the processor's load/store traffic.
- Decodes a word-addressed window, answers loads with one-cycle registered latency and accepts stores.
- Exposes game state registers (score, bird Y, pipe X) to the renderer.
- Supplies the processor with a debounced flap-button event count and a frame counter.

---
 rtl/flappy_mmio_responder_pkg.sv | 22 ++
 rtl/flappy_mmio_responder_if.sv | 19 +
 rtl/flappy_mmio_responder_debounce.sv | 41 ++++
 rtl/flappy_mmio_responder.sv | 159 +++++++++++++++
 tb/tb_flappy_mmio_responder.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flappy_mmio_responder_pkg.sv
// Shared register map, field widths and STATUS bit positions for the flappy MMIO responder.
package flappy_mmio_pkg;

    localparam int unsigned SCORE_W = 16;
    localparam int unsigned POS_W   = 10;
    localparam int unsigned FLAP_W  = 8;

    localparam logic [3:0] IDX_STATUS = 4'd0;
    localparam logic [3:0] IDX_FLAP   = 4'd1;
    localparam logic [3:0] IDX_FRAME  = 4'd2;
    localparam logic [3:0] IDX_SCORE  = 4'd3;
    localparam logic [3:0] IDX_BIRD_Y = 4'd4;
    localparam logic [3:0] IDX_PIPE_X = 4'd5;

    localparam int unsigned STATUS_FLAP_BIT  = 0;
    localparam int unsigned STATUS_FRAME_BIT = 1;

    function automatic logic [FLAP_W-1:0] flap_sat_inc(input logic [FLAP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/flappy_mmio_responder_if.sv
// Processor data-memory port as seen by the flappy MMIO responder.
interface flappy_mmio_responder_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_hit;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata, mem_hit
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata, mem_hit
    );
endinterface

// File: rtl/flappy_mmio_responder_debounce.sv
// Level debouncer: dout follows din only after din has held a new level
// for DEBOUNCE_CYCLES consecutive clocks.
module flappy_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample that agrees with the current output restarts the count.
    always_comb begin
        dout_d = dout_q;
        cnt_d  = '0;
        if (din != dout_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                dout_d = din;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/flappy_mmio_responder.sv
// Flappy game MMIO responder: register window, frame timer and flap-button counter.
// Define FLAPPY_MMIO_DEBOUNCE_EN to insert flappy_debounce in the button path.
module flappy_mmio_responder
    import flappy_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
    parameter int unsigned FRAME_DIV       = 833333,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                   clock,
    input  logic                   reset,
    flappy_mmio_responder_if.slave bus,
    input  logic                   btn_flap,
    output logic [SCORE_W-1:0]     score,
    output logic [POS_W-1:0]       bird_y,
    output logic [POS_W-1:0]       pipe_x,
    output logic                   frame_tick
);
    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    if (BASE_ADDR[3:0] != 4'h0) begin : g_bad_base
        $error("flappy_mmio_responder: BASE_ADDR low nibble must be zero");
    end
    if (FRAME_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_timing
        $error("flappy_mmio_responder: FRAME_DIV must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic              sync1_q, sync2_q, lvl, lvl_prev_q, flap_edge;
    logic              sel, rd_en, wr_en, status_rd, flap_rd, wrap;
    logic [3:0]        idx;
    logic [31:0]       rd_val;
    logic              unused_wdata;

    logic [SCORE_W-1:0] score_q, score_d;
    logic [POS_W-1:0]   bird_q, bird_d, pipe_q, pipe_d;
    logic [FLAP_W-1:0]  flap_cnt_q, flap_cnt_d;
    logic [31:0]        frame_cnt_q, frame_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               frame_pend_q, frame_pend_d;
    logic               tick_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               hit_q, hit_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            sync1_q    <= btn_flap;
            sync2_q    <= sync1_q;
            lvl_prev_q <= lvl;
        end
    end

`ifdef FLAPPY_MMIO_DEBOUNCE_EN
    flappy_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock(clock),
        .reset(reset),
        .din  (sync2_q),
        .dout (lvl)
    );
`else
    assign lvl = sync2_q;
`endif

    assign flap_edge    = lvl & ~lvl_prev_q;
    assign sel          = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
    assign idx          = bus.mem_addr[3:0];
    assign rd_en        = sel & bus.mem_re;
    assign wr_en        = sel & bus.mem_we;
    assign status_rd    = rd_en && (idx == IDX_STATUS);
    assign flap_rd      = rd_en && (idx == IDX_FLAP);
    assign wrap         = (div_q == DIV_W'(FRAME_DIV - 1));
    assign unused_wdata = ^bus.mem_wdata[31:SCORE_W];

    always_comb begin
        rd_val = '0;
        case (idx)
            IDX_STATUS: begin
                rd_val[STATUS_FLAP_BIT]  = (flap_cnt_q != '0);
                rd_val[STATUS_FRAME_BIT] = frame_pend_q;
            end
            IDX_FLAP:   rd_val = 32'(flap_cnt_q);
            IDX_FRAME:  rd_val = frame_cnt_q;
            IDX_SCORE:  rd_val = 32'(score_q);
            IDX_BIRD_Y: rd_val = 32'(bird_q);
            IDX_PIPE_X: rd_val = 32'(pipe_q);
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        score_d = score_q;
        bird_d  = bird_q;
        pipe_d  = pipe_q;
        if (wr_en) begin
            case (idx)
                IDX_SCORE:  score_d = bus.mem_wdata[SCORE_W-1:0];
                IDX_BIRD_Y: bird_d  = bus.mem_wdata[POS_W-1:0];
                IDX_PIPE_X: pipe_d  = bus.mem_wdata[POS_W-1:0];
                default:    ;
            endcase
        end

        div_d        = wrap ? '0 : div_q + 1'b1;
        frame_cnt_d  = wrap ? frame_cnt_q + 32'd1 : frame_cnt_q;
        // A wrap landing on a STATUS read must not be lost to the clear.
        frame_pend_d = wrap | (frame_pend_q & ~status_rd);

        // Clear-on-read keeps an edge arriving in the same cycle.
        if (flap_rd) begin
            flap_cnt_d = flap_edge ? FLAP_W'(1) : '0;
        end else if (flap_edge) begin
            flap_cnt_d = flap_sat_inc(flap_cnt_q);
        end else begin
            flap_cnt_d = flap_cnt_q;
        end

        rdata_d = rd_en ? rd_val : '0;
        hit_d   = sel & (bus.mem_re | bus.mem_we);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            score_q      <= '0;
            bird_q       <= '0;
            pipe_q       <= '0;
            flap_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            div_q        <= '0;
            frame_pend_q <= 1'b0;
            tick_q       <= 1'b0;
            rdata_q      <= '0;
            hit_q        <= 1'b0;
        end else begin
            score_q      <= score_d;
            bird_q       <= bird_d;
            pipe_q       <= pipe_d;
            flap_cnt_q   <= flap_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            div_q        <= div_d;
            frame_pend_q <= frame_pend_d;
            tick_q       <= wrap;
            rdata_q      <= rdata_d;
            hit_q        <= hit_d;
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_hit   = hit_q;
    assign score         = score_q;
    assign bird_y        = bird_q;
    assign pipe_x        = pipe_q;
    assign frame_tick    = tick_q;

endmodule

// File: tb/tb_flappy_mmio_responder.sv
// Self-checking bench for flappy_mmio_responder with a behavioural reference model.
module tb_flappy_mmio_responder;
    localparam logic [31:0] BASE      = 32'h0000_1000;
    localparam int unsigned FRAME_DIV = 10;
    localparam int unsigned DB        = 4;
`ifdef FLAPPY_MMIO_DEBOUNCE_EN
    localparam int unsigned LAT = 2 + DB;
`else
    localparam int unsigned LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn = 1'b0;
    logic [15:0] score;
    logic [9:0]  bird_y, pipe_x;
    logic        frame_tick;
    int checks = 0;
    int errors = 0;

    flappy_mmio_responder_if bus();

    flappy_mmio_responder #(
        .BASE_ADDR      (BASE),
        .FRAME_DIV      (FRAME_DIV),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock     (clk),
        .reset     (rst),
        .bus       (bus),
        .btn_flap  (btn),
        .score     (score),
        .bird_y    (bird_y),
        .pipe_x    (pipe_x),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: register file, frame timer and button filter described by their rules.
    logic [15:0] m_score;
    logic [9:0]  m_bird, m_pipe;
    logic [7:0]  m_flap;
    logic [31:0] m_frame, m_rdata;
    int unsigned m_div;
    logic        m_pend, m_tick, m_hit;
    logic        h [0:7];
    logic        fh1, fh2;

    always @(posedge clk) begin : model
        logic        sel, edge_now, wrap, fnew, all_same;
        logic [3:0]  idx;
        logic [31:0] val;
        if (rst) begin
            m_score = '0; m_bird = '0; m_pipe = '0; m_flap = '0; m_frame = '0;
            m_rdata = '0; m_div = 0; m_pend = 1'b0; m_tick = 1'b0; m_hit = 1'b0;
            for (int i = 0; i < 8; i++) h[i] = 1'b0;
            fh1 = 1'b0; fh2 = 1'b0;
        end else begin
            sel = (bus.mem_addr / 16) == (BASE / 16);
            idx = bus.mem_addr[3:0];
            edge_now = fh1 && !fh2;
            case (idx)
                4'd0: val = {30'd0, m_pend, (m_flap != 0)};
                4'd1: val = {24'd0, m_flap};
                4'd2: val = m_frame;
                4'd3: val = {16'd0, m_score};
                4'd4: val = {22'd0, m_bird};
                4'd5: val = {22'd0, m_pipe};
                default: val = 32'd0;
            endcase
            m_rdata = (sel && bus.mem_re) ? val : 32'd0;
            m_hit   = sel && (bus.mem_re || bus.mem_we);
            if (sel && bus.mem_we) begin
                if (idx == 4'd3) m_score = bus.mem_wdata[15:0];
                if (idx == 4'd4) m_bird  = bus.mem_wdata[9:0];
                if (idx == 4'd5) m_pipe  = bus.mem_wdata[9:0];
            end
            wrap   = (m_div == FRAME_DIV - 1);
            m_div  = wrap ? 0 : m_div + 1;
            m_tick = wrap;
            if (wrap) m_frame = m_frame + 1;
            if (wrap) m_pend = 1'b1;
            else if (sel && bus.mem_re && idx == 4'd0) m_pend = 1'b0;
            if (sel && bus.mem_re && idx == 4'd1) m_flap = edge_now ? 8'd1 : 8'd0;
            else if (edge_now && m_flap < 8'd255) m_flap = m_flap + 8'd1;
            for (int i = 7; i > 0; i--) h[i] = h[i-1];
            h[0] = btn;
`ifdef FLAPPY_MMIO_DEBOUNCE_EN
            all_same = 1'b1;
            for (int k = 2; k < DB + 2; k++) if (h[k] != h[2]) all_same = 1'b0;
            fnew = (all_same && h[2] != fh1) ? h[2] : fh1;
`else
            fnew = h[1];
`endif
            fh2 = fh1;
            fh1 = fnew;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_re = 1'b0;
        bus.mem_we = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        btn = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic press(input int hold, input int rel);
        btn = 1'b1;
        repeat (hold) tick();
        btn = 1'b0;
        repeat (rel) tick();
    endtask

    task automatic rd_req(input logic [31:0] a);
        bus.mem_addr = a; bus.mem_re = 1'b1; bus.mem_we = 1'b0;
    endtask

    task automatic test_reset();
        bus.mem_addr = BASE + 3; bus.mem_wdata = 32'h1111; bus.mem_we = 1'b1;
        tick();
        do_reset();
        checks++; if (bus.mem_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.mem_rdata); end
        checks++; if (bus.mem_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", bus.mem_hit); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score: got %h expected 0", score); end
        checks++; if (bird_y !== 10'd0 || pipe_x !== 10'd0) begin errors++; $display("FAIL reset_pos: got %h/%h expected 0/0", bird_y, pipe_x); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
    endtask

    task automatic test_rw();
        bus.mem_addr = BASE + 3; bus.mem_wdata = 32'h0000_1234; bus.mem_we = 1'b1; bus.mem_re = 1'b0;
        tick();
        rd_req(BASE + 3);
        tick();
        checks++; if (bus.mem_rdata !== 32'h0000_1234) begin errors++; $display("FAIL rw_score_rdata: got %h expected 00001234", bus.mem_rdata); end
        checks++; if (bus.mem_hit !== 1'b1) begin errors++; $display("FAIL rw_score_hit: got %b expected 1", bus.mem_hit); end
        checks++; if (score !== 16'h1234) begin errors++; $display("FAIL rw_score_port: got %h expected 1234", score); end
        bus.mem_addr = BASE + 4; bus.mem_wdata = 32'hFFFF_FFFF; bus.mem_we = 1'b1; bus.mem_re = 1'b0;
        tick();
        checks++; if (bird_y !== 10'h3FF) begin errors++; $display("FAIL rw_bird_trunc: got %h expected 3ff", bird_y); end
        bus.mem_addr = BASE + 5; bus.mem_wdata = 32'h0000_0155;
        tick();
        bus.mem_wdata = 32'h0000_02AA; bus.mem_re = 1'b1;
        tick();
        checks++; if (bus.mem_rdata !== 32'h0000_0155) begin errors++; $display("FAIL rw_same_cycle_old: got %h expected 00000155", bus.mem_rdata); end
        checks++; if (pipe_x !== 10'h2AA) begin errors++; $display("FAIL rw_same_cycle_new: got %h expected 2aa", pipe_x); end
        bus.mem_addr = BASE + 2; bus.mem_wdata = 32'hDEAD_BEEF; bus.mem_we = 1'b1; bus.mem_re = 1'b0;
        tick();
        bus.mem_addr = BASE + 9; bus.mem_wdata = 32'h0000_0000;
        tick();
        rd_req(BASE + 2);
        tick();
        checks++; if (bus.mem_rdata !== m_rdata) begin errors++; $display("FAIL rw_frame_ro: got %h expected %h", bus.mem_rdata, m_rdata); end
        checks++; if (score !== 16'h1234 || bird_y !== 10'h3FF || pipe_x !== 10'h2AA) begin
            errors++; $display("FAIL rw_ignored_write: got %h/%h/%h expected 1234/3ff/2aa", score, bird_y, pipe_x);
        end
        idle();
    endtask

    task automatic test_decode();
        rd_req(BASE + 16);
        tick();
        checks++; if (bus.mem_hit !== 1'b0 || bus.mem_rdata !== 32'd0) begin errors++; $display("FAIL dec_outside: got hit=%b rdata=%h expected 0/0", bus.mem_hit, bus.mem_rdata); end
        rd_req(BASE + 9);
        tick();
        checks++; if (bus.mem_hit !== 1'b1 || bus.mem_rdata !== 32'd0) begin errors++; $display("FAIL dec_unmapped: got hit=%b rdata=%h expected 1/0", bus.mem_hit, bus.mem_rdata); end
        bus.mem_addr = BASE - 1; bus.mem_re = 1'b1;
        tick();
        checks++; if (bus.mem_hit !== 1'b0) begin errors++; $display("FAIL dec_below: got %b expected 0", bus.mem_hit); end
        bus.mem_addr = BASE + 6; bus.mem_re = 1'b0; bus.mem_we = 1'b1; bus.mem_wdata = 32'h5;
        tick();
        checks++; if (bus.mem_hit !== 1'b1 || bus.mem_rdata !== 32'd0) begin errors++; $display("FAIL dec_write_hit: got hit=%b rdata=%h expected 1/0", bus.mem_hit, bus.mem_rdata); end
        idle();
        tick();
        checks++; if (bus.mem_hit !== 1'b0) begin errors++; $display("FAIL dec_idle: got %b expected 0", bus.mem_hit); end
    endtask

    task automatic test_frame();
        do_reset();
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL frame_tick_c0: got %b expected 0", frame_tick); end
        for (int c = 1; c <= 25; c++) begin
            tick();
            checks++;
            if (frame_tick !== ((c == 10) || (c == 20))) begin errors++; $display("FAIL frame_tick_c%0d: got %b expected %b", c, frame_tick, (c == 10) || (c == 20)); end
        end
        rd_req(BASE + 2);
        tick();
        checks++; if (bus.mem_rdata !== 32'd2) begin errors++; $display("FAIL frame_count: got %h expected 2", bus.mem_rdata); end
        rd_req(BASE + 0);
        tick();
        checks++; if (bus.mem_rdata[1] !== 1'b1) begin errors++; $display("FAIL frame_pend_set: got %b expected 1", bus.mem_rdata[1]); end
        tick();
        checks++; if (bus.mem_rdata[1] !== 1'b0) begin errors++; $display("FAIL frame_pend_clr: got %b expected 0", bus.mem_rdata[1]); end
        idle();
        repeat (10) tick();
        rd_req(BASE + 0);
        tick();
        tick();
        checks++; if (bus.mem_rdata[1] !== 1'b0) begin errors++; $display("FAIL frame_wrap_read_old: got %b expected 0", bus.mem_rdata[1]); end
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL frame_tick_c40: got %b expected 1", frame_tick); end
        tick();
        checks++; if (bus.mem_rdata[1] !== 1'b1) begin errors++; $display("FAIL frame_wrap_keeps_pend: got %b expected 1", bus.mem_rdata[1]); end
        idle();
    endtask

    task automatic test_flap();
        do_reset();
        repeat (8) tick();
        for (int i = 0; i < 3; i++) press(6, 8);
        rd_req(BASE + 0);
        tick();
        checks++; if (bus.mem_rdata[0] !== 1'b1) begin errors++; $display("FAIL flap_status_bit: got %b expected 1", bus.mem_rdata[0]); end
        rd_req(BASE + 1);
        tick();
        checks++; if (bus.mem_rdata !== 32'd3 || bus.mem_rdata !== m_rdata) begin errors++; $display("FAIL flap_three: got %h expected 3 (model %h)", bus.mem_rdata, m_rdata); end
        tick();
        checks++; if (bus.mem_rdata !== 32'd0) begin errors++; $display("FAIL flap_cleared: got %h expected 0", bus.mem_rdata); end
        idle();
        press(6, 8);
        btn = 1'b1;
        repeat (LAT) tick();
        rd_req(BASE + 1);
        tick();
        checks++; if (bus.mem_rdata !== 32'd1 || bus.mem_rdata !== m_rdata) begin errors++; $display("FAIL flap_race_old: got %h expected 1 (model %h)", bus.mem_rdata, m_rdata); end
        idle();
        repeat (4) tick();
        btn = 1'b0;
        repeat (8) tick();
        rd_req(BASE + 1);
        tick();
        checks++; if (bus.mem_rdata !== 32'd1 || bus.mem_rdata !== m_rdata) begin errors++; $display("FAIL flap_race_kept: got %h expected 1 (model %h)", bus.mem_rdata, m_rdata); end
        idle();
    endtask

    task automatic test_chatter();
        logic [31:0] exp;
        do_reset();
        repeat (8) tick();
        for (int i = 0; i < 5; i++) press((i % 2) + 1, 6);
        repeat (8) tick();
`ifdef FLAPPY_MMIO_DEBOUNCE_EN
        exp = 32'd0;
`else
        exp = 32'd5;
`endif
        rd_req(BASE + 1);
        tick();
        checks++; if (bus.mem_rdata !== exp || bus.mem_rdata !== m_rdata) begin errors++; $display("FAIL chatter: got %h expected %h (model %h)", bus.mem_rdata, exp, m_rdata); end
        idle();
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (8) tick();
        for (int i = 0; i < 300; i++) press(5, 5);
        repeat (10) tick();
        rd_req(BASE + 1);
        tick();
        checks++; if (bus.mem_rdata !== 32'd255) begin errors++; $display("FAIL flap_saturate: got %h expected ff", bus.mem_rdata); end
        tick();
        checks++; if (bus.mem_rdata !== 32'd0) begin errors++; $display("FAIL flap_sat_clear: got %h expected 0", bus.mem_rdata); end
        idle();
    endtask

    task automatic test_reset_mid();
        bus.mem_addr = BASE + 3; bus.mem_wdata = 32'h55AA; bus.mem_we = 1'b1; bus.mem_re = 1'b0;
        tick();
        repeat (13) tick();
        rd_req(BASE + 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.mem_hit !== 1'b0 || bus.mem_rdata !== 32'd0) begin errors++; $display("FAIL rstmid_resp: got hit=%b rdata=%h expected 0/0", bus.mem_hit, bus.mem_rdata); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL rstmid_score: got %h expected 0", score); end
        rd_req(BASE + 2);
        tick();
        checks++; if (bus.mem_hit !== 1'b1 || bus.mem_rdata !== 32'd0) begin errors++; $display("FAIL rstmid_frame: got hit=%b rdata=%h expected 1/0", bus.mem_hit, bus.mem_rdata); end
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.mem_addr  = ($urandom_range(0, 7) == 0) ? $urandom() : BASE + $urandom_range(0, 15);
            bus.mem_wdata = $urandom();
            bus.mem_re    = $urandom_range(0, 1);
            bus.mem_we    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) btn = ~btn;
            tick();
            checks++; if (bus.mem_rdata !== m_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", n, bus.mem_rdata, m_rdata); end
            checks++; if (bus.mem_hit !== m_hit) begin errors++; $display("FAIL rand_hit[%0d]: got %b expected %b", n, bus.mem_hit, m_hit); end
            checks++; if (score !== m_score) begin errors++; $display("FAIL rand_score[%0d]: got %h expected %h", n, score, m_score); end
            checks++; if (bird_y !== m_bird || pipe_x !== m_pipe) begin errors++; $display("FAIL rand_pos[%0d]: got %h/%h expected %h/%h", n, bird_y, pipe_x, m_bird, m_pipe); end
            checks++; if (frame_tick !== m_tick) begin errors++; $display("FAIL rand_tick[%0d]: got %b expected %b", n, frame_tick, m_tick); end
        end
        idle();
        btn = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_re = 1'b0; bus.mem_we = 1'b0;
        #1;
        test_reset();
        test_rw();
        test_decode();
        test_frame();
        test_flap();
        test_chatter();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
